// File: rtl/calc_sequencer_pkg.sv
// calc_sequencer_pkg: state encodings, flag bit indices and progress LED patterns
package calc_sequencer_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WITH_A = 3'd1;
    localparam logic [2:0] S_WITH_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;
    localparam int F_ZERO  = 0;
    localparam int F_OVF   = 1;
    localparam int F_CARRY = 2;
    localparam logic [3:0] LED_IDLE   = 4'b0001;
    localparam logic [3:0] LED_WITH_A = 4'b0011;
    localparam logic [3:0] LED_WITH_B = 4'b0111;
    localparam logic [3:0] LED_EXEC   = 4'b0111;
    localparam logic [3:0] LED_RESULT = 4'b1111;
    localparam logic [3:0] LED_ERROR  = 4'b1001;
    function automatic logic [3:0] stage_pattern(input logic [2:0] s);
        return s == S_WITH_A ? LED_WITH_A :
               s == S_WITH_B ? LED_WITH_B :
               s == S_EXEC   ? LED_EXEC   :
               s == S_RESULT ? LED_RESULT :
               s == S_ERROR  ? LED_ERROR  : LED_IDLE;
    endfunction
endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: operand/start/done handshake between the sequencer and the ALU
interface calc_sequencer_if #(parameter int WIDTH = 8, parameter int OPW = 4);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_flags;
    modport master(output alu_a, alu_b, alu_op, alu_start, input alu_done, alu_result, alu_flags);
    modport slave(input alu_a, alu_b, alu_op, alu_start, output alu_done, alu_result, alu_flags);
endinterface

// File: rtl/calc_sequencer_rise_detect.sv
// calc_sequencer_rise_detect: Enter rising-edge detector; history resets high so a held button is not a press
module calc_sequencer_rise_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic rise
);
    logic level_q;
    always_ff @(posedge clock) begin
        if (!reset_n) level_q <= 1'b1;
        else level_q <= level;
    end
    assign rise = level & ~level_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: captures A, B and opcode on Enter presses, runs the ALU handshake, latches result/flags
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OPW        = 4,
    parameter int CHAIN_MODE = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [OPW-1:0]       op_in,
    input  logic                 enter,
    input  logic                 clear,
    calc_sequencer_if.master     alu,
    output logic [WIDTH-1:0]     result,
    output logic [2:0]           flags,
    output logic                 show_a,
    output logic                 show_b,
    output logic                 show_r,
    output logic [3:0]           stage_leds,
    output logic                 busy,
    output logic                 error
);
    localparam int CW = TIMEOUT == 0 ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    logic [2:0]    state;
    logic [CW-1:0] counter;
    logic          rise;
    logic          kill;
    calc_sequencer_rise_detect u_rise (
        .clock  (clock),
        .reset_n(reset_n),
        .level  (enter),
        .rise   (rise)
    );
    // clear, leaving ERROR and illegal encodings all return to a zeroed IDLE
    assign kill = clear || state > S_ERROR || (state == S_ERROR && rise);
    always_ff @(posedge clock) begin
        if (!reset_n || kill) begin
            state         <= S_IDLE;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_op    <= '0;
            alu.alu_start <= 1'b0;
            result        <= '0;
            flags         <= '0;
            counter       <= '0;
        end else begin
            alu.alu_start <= 1'b0;
            case (state)
                S_IDLE: if (rise) begin
                    alu.alu_a <= data_in;
                    state     <= S_WITH_A;
                end
                S_WITH_A: if (rise) begin
                    alu.alu_b <= data_in;
                    state     <= S_WITH_B;
                end
                S_WITH_B: if (rise) begin
                    alu.alu_op    <= op_in;
                    alu.alu_start <= 1'b1;
                    counter       <= '0;
                    state         <= S_EXEC;
                end
                S_EXEC: if (alu.alu_done) begin
                    result <= alu.alu_result;
                    flags  <= alu.alu_flags;
                    state  <= S_RESULT;
                end else if (TIMEOUT != 0 && counter == LAST) begin
                    state <= S_ERROR;
                end else begin
                    counter <= counter + 1'b1;
                end
                S_RESULT: if (rise) begin
                    alu.alu_a <= CHAIN_MODE != 0 ? result : data_in;
                    alu.alu_b <= '0;
                    state     <= S_WITH_A;
                end
                default: ;
            endcase
        end
    end
    assign busy       = state == S_EXEC;
    assign error      = state == S_ERROR;
    assign show_a     = state inside {S_WITH_A, S_WITH_B, S_EXEC, S_RESULT};
    assign show_b     = state inside {S_WITH_B, S_EXEC, S_RESULT};
    assign show_r     = state == S_RESULT;
    assign stage_leds = stage_pattern(state);
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table-driven operations with an ALU responder and result scoreboard, plus corner sequences
module tb_calc_sequencer;
    localparam int WIDTH = 8, OPW = 4, TIMEOUT = 4;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        int         lat;
        logic [7:0] r;
        logic [2:0] f;
    } vec_t;
    typedef struct {
        logic [7:0] r;
        logic [2:0] f;
    } exp_t;
    logic clock = 0, reset_n = 0, enter = 0, clear = 0;
    logic [7:0] data_in = 0;
    logic [3:0] op_in = 0;
    logic [7:0] result;
    logic [2:0] flags;
    logic show_a, show_b, show_r, busy, error;
    logic [3:0] stage_leds;
    int checks = 0, errors = 0, starts = 0, alu_lat = 0, alu_cnt = -1;
    bit alu_enable = 1;
    exp_t sb[$];
    vec_t vecs[7];
    calc_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus();
    calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CHAIN_MODE(1), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .op_in(op_in),
        .enter(enter), .clear(clear), .alu(bus), .result(result), .flags(flags),
        .show_a(show_a), .show_b(show_b), .show_r(show_r), .stage_leds(stage_leds),
        .busy(busy), .error(error)
    );
    always #5 clock = ~clock;
    // ALU responder: 0 ADD, 1 SUB (carry = borrow), 2 AND, other XOR; done alu_lat cycles after start
    always @(negedge clock) begin
        logic [8:0] w;
        logic ovf;
        bus.alu_done = 1'b0;
        if (bus.alu_start === 1'b1) begin
            starts++;
            alu_cnt = alu_lat;
        end
        if (alu_cnt == 0 && alu_enable) begin
            case (bus.alu_op)
                4'd0: w = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                4'd1: w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                4'd2: w = {1'b0, bus.alu_a & bus.alu_b};
                default: w = {1'b0, bus.alu_a ^ bus.alu_b};
            endcase
            ovf = bus.alu_op == 4'd0 ? (bus.alu_a[7] == bus.alu_b[7] && w[7] != bus.alu_a[7]) :
                  bus.alu_op == 4'd1 ? (bus.alu_a[7] != bus.alu_b[7] && w[7] != bus.alu_a[7]) : 1'b0;
            bus.alu_result = w[7:0];
            bus.alu_flags  = {w[8], ovf, w[7:0] == 8'd0};
            bus.alu_done   = 1'b1;
        end
        if (alu_cnt >= 0) alu_cnt--;
    end
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic press(input logic [7:0] d, input logic [3:0] o);
        data_in = d;
        op_in = o;
        enter = 1;
        step();
        enter = 0;
        step();
    endtask
    task automatic wait_done();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("exec_bounded", {31'd0, busy}, 0);
    endtask
    task automatic compare_sb();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sb_result", {24'd0, result}, {24'd0, e.r});
            chk("sb_flags", {29'd0, flags}, {29'd0, e.f});
        end
    endtask
    task automatic run(input vec_t v);
        exp_t e;
        int s0;
        clear = 1;
        step();
        clear = 0;
        chk("clr_idle", {28'd0, stage_leds}, 4'b0001);
        press(v.a, 4'd0);
        chk("with_a_leds", {28'd0, stage_leds}, 4'b0011);
        chk("cap_a", {24'd0, bus.alu_a}, {24'd0, v.a});
        press(v.b, 4'd0);
        chk("with_b_leds", {28'd0, stage_leds}, 4'b0111);
        chk("cap_b", {24'd0, bus.alu_b}, {24'd0, v.b});
        alu_lat = v.lat;
        e.r = v.r;
        e.f = v.f;
        sb.push_back(e);
        s0 = starts;
        press(8'hEE, v.op);
        wait_done();
        chk("start_pulses", starts - s0, 1);
        chk("result_leds", {28'd0, stage_leds}, 4'b1111);
        chk("show_r", {31'd0, show_r}, 1);
        chk("op_held", {28'd0, bus.alu_op}, {28'd0, v.op});
        compare_sb();
    endtask
    initial begin
        int n;
        int s0;
        exp_t e;
        vecs[0] = '{8'd25,  8'd17,  4'd0, 2, 8'd42,  3'b000};
        vecs[1] = '{8'd200, 8'd100, 4'd0, 0, 8'd44,  3'b100};
        vecs[2] = '{8'd100, 8'd100, 4'd0, 1, 8'd200, 3'b010};
        vecs[3] = '{8'd5,   8'd5,   4'd1, 3, 8'd0,   3'b001};
        vecs[4] = '{8'd3,   8'd10,  4'd1, 0, 8'd249, 3'b100};
        vecs[5] = '{8'hF0,  8'h0F,  4'd2, 1, 8'd0,   3'b001};
        vecs[6] = '{8'hAA,  8'h0F,  4'd3, 2, 8'hA5,  3'b000};
        repeat (3) step();
        chk("rst_leds", {28'd0, stage_leds}, 4'b0001);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_flags", {29'd0, flags}, 0);
        chk("rst_a", {24'd0, bus.alu_a}, 0);
        chk("rst_op", {28'd0, bus.alu_op}, 0);
        chk("rst_start", {31'd0, bus.alu_start}, 0);
        chk("rst_busy_err", {30'd0, busy, error}, 0);
        chk("rst_show", {29'd0, show_a, show_b, show_r}, 0);
        reset_n = 1;
        step();
        foreach (vecs[i]) run(vecs[i]);
        // chaining: Enter in RESULT loads the result into A
        run(vecs[0]);
        press(8'd99, 4'd0);
        chk("chain_a", {24'd0, bus.alu_a}, 42);
        chk("chain_b_zero", {24'd0, bus.alu_b}, 0);
        chk("chain_leds", {28'd0, stage_leds}, 4'b0011);
        press(8'd8, 4'd0);
        alu_lat = 1;
        e.r = 8'd50;
        e.f = 3'b000;
        sb.push_back(e);
        press(8'd0, 4'd0);
        wait_done();
        compare_sb();
        // timeout from a chained operation: result 50 must survive
        press(8'd0, 4'd0);
        press(8'd2, 4'd0);
        alu_enable = 0;
        op_in = 4'd0;
        enter = 1;
        step();
        enter = 0;
        chk("to_exec", {31'd0, busy}, 1);
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_error", {31'd0, error}, 1);
        chk("to_leds", {28'd0, stage_leds}, 4'b1001);
        chk("to_result_kept", {24'd0, result}, 50);
        chk("to_show", {29'd0, show_a, show_b, show_r}, 0);
        alu_enable = 1;
        press(8'd0, 4'd0);
        chk("err_exit_leds", {28'd0, stage_leds}, 4'b0001);
        chk("err_exit_result", {24'd0, result}, 0);
        chk("err_exit_a", {24'd0, bus.alu_a}, 0);
        // Enter held for 20 cycles is a single press
        data_in = 8'd33;
        enter = 1;
        repeat (20) step();
        chk("held_leds", {28'd0, stage_leds}, 4'b0011);
        chk("held_a", {24'd0, bus.alu_a}, 33);
        enter = 0;
        step();
        // Enter held through reset release is not a press
        reset_n = 0;
        enter = 1;
        data_in = 8'd77;
        repeat (3) step();
        reset_n = 1;
        repeat (5) step();
        chk("rst_held_leds", {28'd0, stage_leds}, 4'b0001);
        chk("rst_held_a", {24'd0, bus.alu_a}, 0);
        enter = 0;
        step();
        chk("rst_rel_leds", {28'd0, stage_leds}, 4'b0001);
        press(8'd77, 4'd0);
        chk("repress_a", {24'd0, bus.alu_a}, 77);
        // clear in EXEC cycle 2 with done arriving in cycle 3
        clear = 1;
        step();
        clear = 0;
        press(8'd9, 4'd0);
        press(8'd4, 4'd0);
        alu_lat = 2;
        s0 = starts;
        op_in = 4'd0;
        enter = 1;
        step();
        enter = 0;
        step();
        chk("abort_exec2", {31'd0, busy}, 1);
        clear = 1;
        step();
        clear = 0;
        chk("abort_idle", {28'd0, stage_leds}, 4'b0001);
        repeat (3) step();
        chk("abort_stays_idle", {28'd0, stage_leds}, 4'b0001);
        chk("abort_result", {24'd0, result}, 0);
        chk("abort_no_r", {30'd0, show_r, busy}, 0);
        chk("abort_starts", starts - s0, 1);
        // clear beats an Enter rise in WITH_B
        press(8'd5, 4'd0);
        press(8'd6, 4'd0);
        op_in = 4'd5;
        clear = 1;
        enter = 1;
        step();
        chk("clr_enter_leds", {28'd0, stage_leds}, 4'b0001);
        chk("clr_enter_op", {28'd0, bus.alu_op}, 0);
        chk("clr_enter_a", {24'd0, bus.alu_a}, 0);
        clear = 0;
        enter = 0;
        step();
        chk("clr_enter_after", {28'd0, stage_leds}, 4'b0001);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Parametrised successor to the calculator controller. Captures operand A, operand B and opcode from switches on debounced Enter rising edges, then drives an external (possibly multi-cycle) ALU through a start/done handshake. Latches result and flags, supports accumulator chaining, and flags an error on ALU timeout. Sits between the switch/button inputs and the ALU + BCD/display path; display decoders consume its show_* qualifiers and held values.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
OPW, 4, opcode width in bits
CHAIN_MODE, 1, 1: Enter in RESULT loads result into A; 0: Enter in RESULT loads switches into A
TIMEOUT, 16, max EXEC cycles awaiting alu_done; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
data_in  in  WIDTH  operand switches
op_in  in  OPW  opcode switches
enter  in  1  Enter button level, already synchronised
clear  in  1  Clear button level, already synchronised
alu_a  out  WIDTH  operand A to ALU (registered)
alu_b  out  WIDTH  operand B to ALU (registered)
alu_op  out  OPW  opcode to ALU (registered)
alu_start  out  1  one-cycle start pulse
alu_done  in  1  ALU result valid
alu_result  in  WIDTH  ALU result
alu_flags  in  3  {carry, overflow, zero}
result  out  WIDTH  latched result
flags  out  3  latched flags
show_a / show_b / show_r  out  1 each  display-enable qualifiers
stage_leds  out  4  progress LEDs
busy  out  1  high in EXEC
error  out  1  high in ERROR

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; alu_a, alu_b, alu_op, result, flags, counter = 0; alu_start=0; enter_q=1, so a held Enter is not a press.
- enter_rise = enter & ~enter_q; enter_q <= enter every cycle. Only rising edges act; holding Enter N cycles = one press. Action visible the cycle after the sampling edge.
- clear (level) has priority over enter_rise in the same cycle. In any state other than IDLE it zeros A, B, op, result, flags and goes to IDLE next cycle.
- IDLE: stage_leds=0001; show_*=0. enter_rise -> alu_a<=data_in, go WITH_A.
- WITH_A: stage_leds=0011; show_a=1. enter_rise -> alu_b<=data_in, go WITH_B.
- WITH_B: stage_leds=0111; show_a=show_b=1. enter_rise -> alu_op<=op_in, counter<=0, go EXEC.
- EXEC: busy=1; alu_start=1 only in first EXEC cycle. alu_a/b/op stable throughout. alu_done may arrive in that same cycle.
  - alu_done=1 -> result<=alu_result, flags<=alu_flags, go RESULT.
  - Otherwise counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1 without done -> go ERROR; result, flags unchanged.
  - clear aborts to IDLE; a later alu_done is ignored.
  - enter ignored.
- RESULT: stage_leds=1111; show_a=show_b=show_r=1. enter_rise: CHAIN_MODE=1 -> alu_a<=result, alu_b<=0, go WITH_A. CHAIN_MODE=0 -> alu_a<=data_in, alu_b<=0, go WITH_A.
- ERROR: stage_leds=1001; error=1; show_*=0. enter_rise or clear -> IDLE with all data regs zeroed.
- alu_done outside EXEC: ignored.
- Counter width: $clog2(TIMEOUT+1), minimum 1.
- Illegal state encodings -> IDLE next cycle with data regs zeroed.

Decomposition:
- calc_pkg: state enum (IDLE, WITH_A, WITH_B, EXEC, RESULT, ERROR), flag bit indices (ZERO=0, OVF=1, CARRY=2), LED pattern constants.
- One sub-module, rise_detect: enter_q register plus rising-edge output; reset value 1.

Test Plan:
- WIDTH=8: press with data_in=25, press 17, press op=ADD; ALU done after 3 cycles with 42 -> alu_start high exactly 1 cycle; result=42; stage_leds=1111; busy low after done.
- CHAIN_MODE=1 after result 42: press, data_in=8, press op=ADD -> alu_a=42, alu_b=8; result=50.
- Enter held 20 cycles in IDLE -> exactly one transition to WITH_A; held Enter through reset release -> no capture until release and re-press.
- TIMEOUT=4, alu_done never asserted -> ERROR after exactly 4 EXEC cycles; error=1; stage_leds=1001; press Enter -> IDLE.
- Clear in EXEC cycle 2, alu_done in cycle 3 -> IDLE; result stays 0; no RESULT entry.
- clear and enter rise in same WITH_B cycle -> IDLE; alu_op unchanged (0).
